mdu: RTL and testbench

Multiply/divide unit for the EX stage, running beside the integer ALU on the same forwarded srca/srcb operands. Executes MULT/MULTU in 2 cycles and DIV/DIVU over 33 cycles via a serial restoring divider. Owns the architectural HI/LO registers, handles MTHI/MTLO, and raises busy so the hazard unit stalls the pipeline until results are written.

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mdu_div.sv | 87 ++++++++
 rtl/mdu.sv | 119 +++++++++++
 tb/tb_mdu.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the multiply/divide unit.
//   mdu_op_t    - operation encoding presented on mdu.func
//   mdu_state_t - control FSM state encoding
//   DIV_ITER    - number of restoring-divide iterations (one per cycle)
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIN  = 2'b11
    } mdu_state_t;

    localparam int DIV_ITER = 32;

endpackage

// File: rtl/mdu_div.sv
// mdu_div: serial restoring divider, one quotient bit per enabled cycle.
// Ports:
//   i_clk, i_rst_n      - clock, asynchronous active-low reset
//   i_load              - latch operand magnitudes/signs, clear counter
//   i_signed            - operands are two's complement (DIV) when high
//   i_srca, i_srcb      - dividend, divisor
//   i_step              - perform one restoring iteration this cycle
//   o_last              - the iteration taking place this cycle is the final one
//   o_quo, o_rem        - sign-corrected quotient and remainder
module mdu_div
    import mdu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_signed,
    input  logic [31:0] i_srca,
    input  logic [31:0] i_srcb,
    input  logic        i_step,
    output logic        o_last,
    output logic [31:0] o_quo,
    output logic [31:0] o_rem
);

    localparam int CW = $clog2(DIV_ITER);

    logic [63:0]   r_sr;       // {remainder, quotient}
    logic [31:0]   r_divisor;
    logic [31:0]   r_srca_raw; // divide-by-zero returns the raw dividend in HI
    logic [CW-1:0] r_cnt;
    logic          r_qneg;
    logic          r_rneg;
    logic          r_dz;

    logic          w_sa;
    logic          w_sb;
    logic [31:0]   w_abs_a;
    logic [31:0]   w_abs_b;
    logic [32:0]   w_trial;

    assign w_sa    = i_signed & i_srca[31];
    assign w_sb    = i_signed & i_srcb[31];
    assign w_abs_a = w_sa ? (32'd0 - i_srca) : i_srca;
    assign w_abs_b = w_sb ? (32'd0 - i_srcb) : i_srcb;

    // Top 33 bits of the shifted register minus the divisor; bit 32 set means negative.
    assign w_trial = r_sr[63:31] - {1'b0, r_divisor};

    assign o_last = i_step && (r_cnt == CW'(DIV_ITER - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr       <= '0;
            r_divisor  <= '0;
            r_srca_raw <= '0;
            r_cnt      <= '0;
            r_qneg     <= 1'b0;
            r_rneg     <= 1'b0;
            r_dz       <= 1'b0;
        end else if (i_load) begin
            r_sr       <= {32'd0, w_abs_a};
            r_divisor  <= w_abs_b;
            r_srca_raw <= i_srca;
            r_cnt      <= '0;
            r_qneg     <= w_sa ^ w_sb;
            r_rneg     <= w_sa;
            r_dz       <= (i_srcb == 32'd0);
        end else if (i_step) begin
            r_cnt <= r_cnt + 1'b1;
            if (!w_trial[32]) begin
                r_sr <= {w_trial[31:0], r_sr[30:0], 1'b1};
            end else begin
                r_sr <= {r_sr[62:0], 1'b0};
            end
        end
    end

    always_comb begin
        o_quo = r_qneg ? (32'd0 - r_sr[31:0])  : r_sr[31:0];
        o_rem = r_rneg ? (32'd0 - r_sr[63:32]) : r_sr[63:32];
        if (r_dz) begin
            o_quo = 32'hFFFF_FFFF;
            o_rem = r_srca_raw;
        end
    end

endmodule

// File: rtl/mdu.sv
// mdu: EX-stage multiply/divide unit owning the HI/LO registers.
//   state | meaning
//   IDLE  | accept MULT/DIV/MTHI/MTLO requests
//   MUL   | product latched; write HI/LO at closing edge (done=1)
//   DIV   | restoring divider iterating, one bit per cycle
//   FIN   | divider finished; write HI/LO at closing edge (done=1)
// Ports:
//   clk, resetn       - clock, asynchronous active-low reset
//   start, func       - op request (sampled only while idle)
//   srca, srcb        - operands
//   flush             - cancels any op in flight, beats start
//   busy, done        - multi-cycle op in progress / HI-LO write pulse
//   hi, lo            - architectural HI/LO registers
module mdu
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [2:0]  func,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_t r_state;
    logic [63:0] r_prod;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    mdu_op_t     w_op;
    logic        w_accept;
    logic        w_signed;
    logic [63:0] w_a64;
    logic [63:0] w_b64;
    logic [63:0] w_prod;
    logic        w_div_load;
    logic        w_div_step;
    logic        w_div_last;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_op     = mdu_op_t'(func);
    assign w_accept = (r_state == ST_IDLE) && start && !flush;
    assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);

    // Low 64 bits of a 64x64 multiply on extended operands equal the
    // signed or unsigned 32x32 product, depending on the extension.
    assign w_a64  = {{32{w_signed & srca[31]}}, srca};
    assign w_b64  = {{32{w_signed & srcb[31]}}, srcb};
    assign w_prod = w_a64 * w_b64;

    assign w_div_load = w_accept && ((w_op == OP_DIV) || (w_op == OP_DIVU));
    assign w_div_step = (r_state == ST_DIV) && !flush;

    mdu_div u_div (
        .i_clk    (clk),
        .i_rst_n  (resetn),
        .i_load   (w_div_load),
        .i_signed (w_signed),
        .i_srca   (srca),
        .i_srcb   (srcb),
        .i_step   (w_div_step),
        .o_last   (w_div_last),
        .o_quo    (w_quo),
        .o_rem    (w_rem)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_prod  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        case (w_op)
                            OP_MTHI:  r_hi <= srca;
                            OP_MTLO:  r_lo <= srca;
                            OP_MULT, OP_MULTU: begin
                                r_prod  <= w_prod;
                                r_state <= ST_MUL;
                            end
                            OP_DIV, OP_DIVU: r_state <= ST_DIV;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    r_hi    <= r_prod[63:32];
                    r_lo    <= r_prod[31:0];
                    r_state <= ST_IDLE;
                end
                ST_DIV: begin
                    if (w_div_last) r_state <= ST_FIN;
                end
                default: begin
                    r_hi    <= w_rem;
                    r_lo    <= w_quo;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = ((r_state == ST_MUL) || (r_state == ST_FIN)) && !flush;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  func = 3'b000;
    logic [31:0] srca = '0;
    logic [31:0] srcb = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    mdu dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .func   (func),
        .srca   (srca),
        .srcb   (srcb),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        func  = f;
        srca  = a;
        srcb  = b;
        tick();
        start = 1'b0;
        func  = 3'b000;
    endtask

    task automatic run_mul(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(f, a, b);
        check({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
        check({tag, "_done_mid"}, {31'd0, done}, 32'd1);
        tick();
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, "_done_end"}, {31'd0, done}, 32'd0);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    task automatic run_div(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int nbusy = 0;
        int ndone = 0;
        issue(f, a, b);
        for (int i = 0; i < 40 && busy; i++) begin
            nbusy++;
            if (done) ndone++;
            tick();
        end
        check({tag, "_busy_cycles"}, nbusy, 32'd33);
        check({tag, "_done_pulses"}, ndone, 32'd1);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        #12 resetn = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        tick();

        // MTHI / MTLO
        issue(3'b101, 32'h1234_5678, 32'd0);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo", lo, 32'd0);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(3'b110, 32'hCAFE_BABE, 32'd0);
        check("mtlo_lo", lo, 32'hCAFE_BABE);
        check("mtlo_hi", hi, 32'h1234_5678);
        check("mtlo_busy", {31'd0, busy}, 32'd0);

        // func 111 is a no-op
        issue(3'b111, 32'hDEAD_BEEF, 32'd1);
        check("op7_busy", {31'd0, busy}, 32'd0);
        check("op7_hi", hi, 32'h1234_5678);

        run_mul("mult",  3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_mul("multu", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
        run_mul("mult_neg", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

        run_div("div_m7_2",  3'b011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_div("divu_big",  3'b100, 32'h8000_0000, 32'd3, 32'd2, 32'h2AAA_AAAA);
        run_div("divu_dz",   3'b100, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run_div("div_dz",    3'b011, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_div("div_ovf",   3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_div("div_7_m2",  3'b011, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

        // flush during DIV iteration 10
        issue(3'b101, 32'h11, 32'd0);
        issue(3'b110, 32'h22, 32'd0);
        issue(3'b011, 32'd100, 32'd7);
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        check("flush_div_done", {31'd0, done}, 32'd0);
        tick();
        flush = 1'b0;
        check("flush_div_busy", {31'd0, busy}, 32'd0);
        check("flush_div_hi", hi, 32'h11);
        check("flush_div_lo", lo, 32'h22);
        run_mul("post_flush", 3'b010, 32'd3, 32'd4, 32'd0, 32'd12);

        // flush in MUL state forces done low and keeps HI/LO
        issue(3'b010, 32'd9, 32'd9);
        flush = 1'b1;
        #1;
        check("flush_mul_done", {31'd0, done}, 32'd0);
        tick();
        flush = 1'b0;
        check("flush_mul_busy", {31'd0, busy}, 32'd0);
        check("flush_mul_lo", lo, 32'd12);

        // start and flush together: op dropped
        start = 1'b1;
        func  = 3'b100;
        srca  = 32'd50;
        srcb  = 32'd5;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("sf_busy", {31'd0, busy}, 32'd0);
        tick();
        check("sf_busy2", {31'd0, busy}, 32'd0);
        check("sf_lo", lo, 32'd12);

        // asynchronous reset mid-DIV
        issue(3'b101, 32'hA5A5_0000, 32'd0);
        issue(3'b011, 32'd1000, 32'd3);
        tick();
        tick();
        #2;
        check("ar_busy_pre", {31'd0, busy}, 32'd1);
        resetn = 1'b0;
        #1;
        check("ar_busy", {31'd0, busy}, 32'd0);
        check("ar_hi", hi, 32'd0);
        check("ar_lo", lo, 32'd0);
        #3;
        resetn = 1'b1;
        tick();
        run_mul("post_rst", 3'b001, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
